// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-RAM access controller.
package mem_ctrl_pkg;

  localparam int DEFAULT_SIZE_ADDR = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/mem_ctrl.sv
// CPU-to-byte-RAM access controller: splits 8/16-bit loads and stores into
// one or two byte transactions on a byte-wide RAM with ready handshakes.
//
// state | meaning
// IDLE  | waiting for req; captures the access on acceptance
// ISSUE | one-cycle RAM strobe for the current byte
// WAIT  | waiting for RAM ready; latches load data
// DONE  | one-cycle done pulse, then back to IDLE
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int size_addr = DEFAULT_SIZE_ADDR
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req,
  input  logic                 we,
  input  logic                 wide,
  input  logic [size_addr-1:0] addr,
  input  logic [15:0]          wdata,
  output logic [15:0]          rdata,
  output logic                 busy,
  output logic                 done,
  output logic                 ram_read,
  output logic                 ram_write,
  output logic [size_addr-1:0] ram_address,
  output logic [7:0]           ram_wdata,
  input  logic [7:0]           ram_rdata,
  input  logic                 ram_ready_r,
  input  logic                 ram_ready_w
);

  state_t               state;
  logic                 idx;
  logic                 cap_we;
  logic                 cap_wide;
  logic [size_addr-1:0] cap_addr;
  logic [15:0]          cap_wdata;
  logic                 ready;

  // Handshake that ends WAIT depends on the captured direction.
  assign ready = cap_we ? ram_ready_w : ram_ready_r;

  // FSM with all outputs registered; strobes are set on entry to ISSUE so
  // they are high exactly while the FSM sits in ISSUE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= 1'b0;
      cap_we      <= 1'b0;
      cap_wide    <= 1'b0;
      cap_addr    <= '0;
      cap_wdata   <= '0;
      rdata       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      ram_read    <= 1'b0;
      ram_write   <= 1'b0;
      ram_address <= '0;
      ram_wdata   <= '0;
    end else begin
      done      <= 1'b0;
      ram_read  <= 1'b0;
      ram_write <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            cap_we      <= we;
            cap_wide    <= wide;
            cap_addr    <= addr;
            cap_wdata   <= wdata;
            idx         <= 1'b0;
            busy        <= 1'b1;
            ram_read    <= ~we;
            ram_write   <= we;
            ram_address <= addr;
            ram_wdata   <= wdata[7:0];
            state       <= ISSUE;
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (ready) begin
            if (!cap_we) begin
              if (!idx) begin
                rdata[7:0] <= ram_rdata;
                if (!cap_wide) rdata[15:8] <= 8'h00;
              end else begin
                rdata[15:8] <= ram_rdata;
              end
            end
            if (cap_wide && !idx) begin
              idx         <= 1'b1;
              ram_read    <= ~cap_we;
              ram_write   <= cap_we;
              // High byte address wraps modulo 2^size_addr.
              ram_address <= cap_addr + size_addr'(1);
              ram_wdata   <= cap_wdata[15:8];
              state       <= ISSUE;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl attached to a 256-byte RAM model with
// one-cycle ready responses and a reset that clears the array.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        we;
  logic        wide;
  logic [7:0]  addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        busy;
  logic        done;
  logic        ram_read;
  logic        ram_write;
  logic [7:0]  ram_address;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  logic        ram_ready_r;
  logic        ram_ready_w;

  logic [7:0]  mem [0:255];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_ctrl #(.size_addr(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .we         (we),
    .wide       (wide),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .busy       (busy),
    .done       (done),
    .ram_read   (ram_read),
    .ram_write  (ram_write),
    .ram_address(ram_address),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .ram_ready_r(ram_ready_r),
    .ram_ready_w(ram_ready_w)
  );

  // Byte-wide RAM: ready follows the strobe by one cycle.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      ram_ready_r <= 1'b0;
      ram_ready_w <= 1'b0;
      ram_rdata   <= 8'h00;
    end else begin
      ram_ready_r <= ram_read;
      ram_ready_w <= ram_write;
      if (ram_write) mem[ram_address] <= ram_wdata;
      if (ram_read) ram_rdata <= mem[ram_address];
    end
  end

  // Strobes must be mutually exclusive in every cycle.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      n_checks++;
      assert ((ram_read & ram_write) === 1'b0) else begin
        n_fail++;
        $error("FAIL strobe_excl: observed read=%b write=%b required not both", ram_read, ram_write);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one access and count cycles until done; cycle 0 is the req cycle.
  task automatic access(input logic w, input logic wd, input logic [7:0] a,
                        input logic [15:0] d, input int exp_c, input string tag);
    int c;
    c = 0;
    req = 1'b1; we = w; wide = wd; addr = a; wdata = d;
    do begin
      tick();
      c++;
      req = 1'b0;
    end while (done !== 1'b1 && c < 20);
    check({tag, "_done_cycle"}, c, exp_c);
    tick();
    check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_idle_done"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int nz;
    reset = 1'b1; req = 1'b0; we = 1'b0; wide = 1'b0; addr = 8'h00; wdata = 16'h0000;
    repeat (3) tick();
    check("rst_busy",  {31'd0, busy}, 32'd0);
    check("rst_done",  {31'd0, done}, 32'd0);
    check("rst_read",  {31'd0, ram_read}, 32'd0);
    check("rst_write", {31'd0, ram_write}, 32'd0);
    check("rst_rdata", {16'd0, rdata}, 32'h0000);
    check("rst_addr",  {24'd0, ram_address}, 32'h00);
    check("rst_wdata", {24'd0, ram_wdata}, 32'h00);
    reset = 1'b0;
    tick();

    access(1'b1, 1'b1, 8'h10, 16'hBEEF, 5, "hw_store");
    check("hw_store_m10", {24'd0, mem[8'h10]}, 32'hEF);
    check("hw_store_m11", {24'd0, mem[8'h11]}, 32'hBE);
    access(1'b0, 1'b1, 8'h10, 16'h0000, 5, "hw_load");
    check("hw_load_rdata", {16'd0, rdata}, 32'hBEEF);

    access(1'b1, 1'b0, 8'h20, 16'h12A5, 3, "b_store");
    check("b_store_m20", {24'd0, mem[8'h20]}, 32'hA5);
    check("b_store_m21", {24'd0, mem[8'h21]}, 32'h00);
    check("b_store_rdata_kept", {16'd0, rdata}, 32'hBEEF);
    access(1'b0, 1'b0, 8'h20, 16'h0000, 3, "b_load");
    check("b_load_rdata", {16'd0, rdata}, 32'h00A5);

    access(1'b1, 1'b1, 8'hFF, 16'h3C4D, 5, "wrap_store");
    check("wrap_mFF", {24'd0, mem[8'hFF]}, 32'h4D);
    check("wrap_m00", {24'd0, mem[8'h00]}, 32'h3C);

    // Reset while waiting for the first byte of a halfword store.
    req = 1'b1; we = 1'b1; wide = 1'b1; addr = 8'h40; wdata = 16'h5566;
    tick();
    req = 1'b0;
    check("mid_issue_write", {31'd0, ram_write}, 32'd1);
    tick();
    check("mid_wait_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_busy",  {31'd0, busy}, 32'd0);
    check("mid_rst_read",  {31'd0, ram_read}, 32'd0);
    check("mid_rst_write", {31'd0, ram_write}, 32'd0);
    for (int k = 0; k < 6; k++) begin
      check("mid_rst_no_done",  {31'd0, done}, 32'd0);
      check("mid_rst_no_write", {31'd0, ram_write}, 32'd0);
      check("mid_rst_idle",     {31'd0, busy}, 32'd0);
      tick();
    end
    nz = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== 8'h00) nz++;
    check("mid_rst_ram_zero", nz, 0);

    // Two halfword loads with req held high throughout.
    access(1'b1, 1'b1, 8'h50, 16'h9A7B, 5, "pre_store");
    req = 1'b1; we = 1'b0; wide = 1'b1; addr = 8'h50; wdata = 16'h0000;
    for (int k = 1; k <= 12; k++) begin
      tick();
      check($sformatf("held_busy_c%0d", k),  {31'd0, busy}, {31'd0, (k % 6) != 0});
      check($sformatf("held_done_c%0d", k),  {31'd0, done}, {31'd0, (k % 6) == 5});
      check($sformatf("held_read_c%0d", k),  {31'd0, ram_read},
            {31'd0, ((k % 6) == 1) || ((k % 6) == 3)});
      check($sformatf("held_write_c%0d", k), {31'd0, ram_write}, 32'd0);
      if (k == 12) req = 1'b0;
    end
    check("held_rdata", {16'd0, rdata}, 32'h9A7B);
    repeat (7) tick();
    check("held_final_idle", {31'd0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter: size_addr, default 8, meaning byte address width, matching the byte-wide RAM it drives.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising clk; the same reset drives the RAM.
REQ-004 req  input  1  CPU access request, sampled only in IDLE.
REQ-005 we  input  1  1 = store, 0 = load; captured with req.
REQ-006 wide  input  1  1 = 16-bit halfword, 0 = single byte; captured with req.
REQ-007 addr  input  size_addr  byte address of the low byte; captured with req.
REQ-008 wdata  input  16  store data, little-endian; captured with req.
REQ-009 rdata  output  16  load result, registered.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 ram_read  output  1  read strobe to RAM.
REQ-013 ram_write  output  1  write strobe to RAM.
REQ-014 ram_address  output  size_addr  byte address to RAM.
REQ-015 ram_wdata  output  8  byte to RAM data input.
REQ-016 ram_rdata  input  8  byte from RAM data output.
REQ-017 ram_ready_r  input  1  RAM read ready, valid one cycle after ram_read.
REQ-018 ram_ready_w  input  1  RAM write ready, valid one cycle after ram_write.

Function
REQ-019 FSM states: IDLE, ISSUE, WAIT, DONE, plus a 1-bit byte index (0 = low byte, 1 = high byte).
REQ-020 IDLE with req=1: capture we, wide, addr, wdata; clear byte index; go to ISSUE. IDLE with req=0: stay in IDLE.
REQ-021 ISSUE: assert ram_read (load) or ram_write (store) for exactly this one cycle; go to WAIT.
REQ-022 ram_address = captured addr + byte index, modulo 2^size_addr; addr = all-ones wraps the high byte to address 0.
REQ-023 ram_wdata = wdata[7:0] for byte index 0 and wdata[15:8] for byte index 1.
REQ-024 WAIT: hold until ram_ready_r (load) or ram_ready_w (store) is high; strobes stay low while waiting.
REQ-025 WAIT with ready on a load: latch ram_rdata into rdata[7:0] (index 0) or rdata[15:8] (index 1).
REQ-026 WAIT with ready: if wide=1 and index=0, set index to 1 and go to ISSUE; otherwise go to DONE.
REQ-027 Byte load (wide=0): rdata[15:8] is written to 8'h00.
REQ-028 Stores leave rdata unchanged.
REQ-029 DONE: done=1 for this one cycle; go to IDLE. A req present during DONE is ignored.
REQ-030 Latency, counting the cycle req is sampled as cycle 0: byte access has done high at cycle 3; halfword access has done high at cycle 5.
REQ-031 Back-to-back: the earliest next acceptance is the IDLE cycle after DONE.
REQ-032 ram_read and ram_write are never high in the same cycle.
REQ-033 ram_read and ram_write are decoded only from registered state; no combinational path from req to the RAM strobes.

Reset
REQ-034 Reset in any state: go to IDLE and clear the byte index.
REQ-035 Reset values: busy=0, done=0, ram_read=0, ram_write=0, rdata=16'h0000, ram_address=0, ram_wdata=8'h00.
REQ-036 Reset mid-operation: no strobe is issued in the cycle after reset; the partial access is abandoned and done is not pulsed.

Structure
REQ-037 A shared package holds the state encoding constants (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, DONE=2'd3) and the default address width.
REQ-038 The block is a single module with no sub-module; the address increment is inline.
REQ-039 The bench instantiates mem_ctrl together with the existing byte-wide RAM, with size 256.

Verification
REQ-040 Halfword store addr=8'h10, wdata=16'hBEEF, then halfword load addr=8'h10 -> RAM[0x10]=8'hEF, RAM[0x11]=8'hBE; rdata=16'hBEEF; done at cycle 5 of each access.
REQ-041 Byte store addr=8'h20, wdata=16'h12A5, then byte load addr=8'h20 -> RAM[0x20]=8'hA5, RAM[0x21] untouched; rdata=16'h00A5; done at cycle 3.
REQ-042 Halfword store addr=8'hFF, wdata=16'h3C4D -> RAM[0xFF]=8'h4D and RAM[0x00]=8'h3C (address wrap).
REQ-043 Reset asserted in WAIT of a halfword store -> next cycle busy=0, no strobes; RAM is all zeros; done never pulses.
REQ-044 req held high continuously for two halfword loads -> second access accepted on the IDLE cycle after DONE; strobes are never both high; busy is low only in IDLE.
